// File: rtl/sdf_1p_1f_split.sv
`default_nettype none
// ============================================================================
// Module      : sdf_1p_1f_split
// Description : SDF actor with a 1:RATE rate. It pops one token from an
//               upstream FWFT FIFO and pushes RATE tokens downstream. The
//               tokens sum exactly to the input token. Tokens 0..RATE-2 carry
//               the equal share. The last token carries the share plus the
//               remainder.
//               Optional macro SDF_SPLIT_SIGNED_EN selects two's-complement
//               tokens, which use a floor arithmetic shift for the share.
//               When the macro is undefined, tokens are unsigned and use a
//               logical shift.
// Revision    : 1.0 - initial release
// ============================================================================
module sdf_1p_1f_split #(
  parameter int WIDTH     = 32,
  parameter int RATE      = 4,
  parameter int LOG2_RATE = 2
) (
  input  logic             ck,
  input  logic             rst,        // asynchronous, active-low
  input  logic [WIDTH-1:0] in0_data,
  input  logic             in0_empty,
  output logic             in0_rd,
  input  logic             out0_full,
  output logic             out0_wr,
  output logic [WIDTH-1:0] out0_data
);

  localparam logic [0:0]           c_IDLE = 1'b0;
  localparam logic [0:0]           c_EMIT = 1'b1;
  localparam logic [LOG2_RATE-1:0] c_LAST = LOG2_RATE'(RATE - 1);

  logic [0:0]           r_state;
  logic [LOG2_RATE-1:0] r_cnt;
  logic [WIDTH-1:0]     r_hold;

  logic [0:0]           w_nstate;
  logic [LOG2_RATE-1:0] w_ncnt;
  logic [WIDTH-1:0]     w_nhold;
  logic                 w_rd;
  logic                 w_wr;
  logic [WIDTH-1:0]     w_data;
  logic [WIDTH-1:0]     w_share;
  logic [WIDTH-1:0]     w_rem;

  // Remainder is the bits shifted out of the share. It is always non-negative.
  assign w_rem = {{(WIDTH-LOG2_RATE){1'b0}}, r_hold[LOG2_RATE-1:0]};

`ifdef SDF_SPLIT_SIGNED_EN
  logic signed [WIDTH-1:0] w_hold_s;
  assign w_hold_s = r_hold;
  // Floor division by RATE. Adding the non-negative remainder restores hold.
  assign w_share  = w_hold_s >>> LOG2_RATE;
`else
  assign w_share  = r_hold >> LOG2_RATE;
`endif

  // Next-state and handshake decode.
  // A pop on the last token of a burst reloads hold with no idle bubble.
  always_comb begin
    w_nstate = r_state;
    w_ncnt   = r_cnt;
    w_nhold  = r_hold;
    w_rd     = 1'b0;
    w_wr     = 1'b0;
    w_data   = '0;
    case (r_state)
      c_IDLE: begin
        if (!in0_empty) begin
          w_rd     = 1'b1;
          w_nhold  = in0_data;
          w_ncnt   = '0;
          w_nstate = c_EMIT;
        end
      end
      c_EMIT: begin
        if (!out0_full) begin
          w_wr = 1'b1;
          if (r_cnt != c_LAST) begin
            w_data = w_share;
            w_ncnt = r_cnt + 1'b1;
          end else begin
            w_data = w_share + w_rem;
            w_ncnt = '0;
            if (!in0_empty) begin
              w_rd    = 1'b1;
              w_nhold = in0_data;
            end else begin
              w_nstate = c_IDLE;
            end
          end
        end
      end
      default: begin
        w_nstate = c_IDLE;
      end
    endcase
  end

  // Outputs are forced low as soon as reset asserts, without waiting for a clock edge.
  assign in0_rd    = rst & w_rd;
  assign out0_wr   = rst & w_wr;
  assign out0_data = rst ? w_data : '0;

  // State, burst counter and held token. An asynchronous reset discards any partial burst.
  always_ff @(posedge ck or negedge rst) begin
    if (!rst) begin
      r_state <= c_IDLE;
      r_cnt   <= '0;
      r_hold  <= '0;
    end else begin
      r_state <= w_nstate;
      r_cnt   <= w_ncnt;
      r_hold  <= w_nhold;
    end
  end

endmodule
`default_nettype wire
